// File: rtl/audio_sched_pkg.sv
// Shared types and defaults for the audio stream scheduler and its arbiter.
package audio_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_WRITE = 2'd2,
        S_DRAIN = 2'd3
    } sched_state_t;

    localparam int AUDIO_BITS_DEF  = 12;
    localparam int N_SRC_DEF       = 4;
    localparam int UNDERRUN_CNT_W  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from
// last_i+1 with wrap-around. Returns one-hot and index forms of the winner.
module rr_arbiter
    import audio_sched_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    localparam int IW   = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [N_SRC-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = IW'((int'(last_i) + k) % N_SRC);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/audio_stream_scheduler.sv
// Round-robin owner of the stereo output write port; one sample per frame.
// Optional underrun_count output is enabled by AUDIO_SCHED_UNDERRUN_CNT_EN.
module audio_stream_scheduler
    import audio_sched_pkg::*;
#(
    parameter int AUDIO_BITS   = AUDIO_BITS_DEF,
    parameter int N_SRC        = N_SRC_DEF,
    parameter int FRAME_CYCLES = 2**AUDIO_BITS
) (
    input  logic                          clk_audio,
    input  logic                          aclr,
    input  logic [N_SRC-1:0]              src_req,
    input  logic [N_SRC-1:0]              src_valid,
    input  logic [N_SRC*2*AUDIO_BITS-1:0] src_data,
    output logic [N_SRC-1:0]              src_ack,
    output logic [N_SRC-1:0]              grant,
    input  logic                          audio_ready,
    output logic                          audio_wreq,
    output logic [2*AUDIO_BITS-1:0]       audio_sample,
    output logic                          underrun
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0]     underrun_count
`endif
);

    localparam int SW = 2 * AUDIO_BITS;
    localparam int IW = $clog2(N_SRC);
    localparam int FW = $clog2(FRAME_CYCLES);

    sched_state_t     state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic             wreq_q, wreq_d;
    logic [SW-1:0]    sample_q, sample_d;
    logic [N_SRC-1:0] ack_q, ack_d;
    logic             underrun_q, underrun_d;

    logic [N_SRC-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic [SW-1:0]    src_word [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
        assign src_word[g] = src_data[g*SW +: SW];
    end

    rr_arbiter #(.N_SRC(N_SRC)) u_arb (
        .req_i  (src_req),
        .last_i (owner_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        frame_d    = '0;
        wreq_d     = 1'b0;
        ack_d      = '0;
        sample_d   = sample_q;
        underrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (|src_req) begin
                    grant_d = arb_gnt;
                    owner_d = arb_idx;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                // Release wins over a transfer offered in the same cycle.
                if (!src_req[owner_q]) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end else if (audio_ready && src_valid[owner_q]) begin
                    wreq_d   = 1'b1;
                    sample_d = src_word[owner_q];
                    ack_d    = grant_q;
                    state_d  = S_WRITE;
                end else if (audio_ready) begin
                    if (frame_q == FW'(FRAME_CYCLES - 1)) begin
                        underrun_d = 1'b1;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
            end
            S_WRITE: state_d = S_DRAIN;
            // Wait for the frame's ready window to close before rearming.
            S_DRAIN: if (!audio_ready) state_d = S_ARM;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_audio or posedge aclr) begin
        if (aclr) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= IW'(N_SRC - 1);
            frame_q    <= '0;
            wreq_q     <= 1'b0;
            sample_q   <= '0;
            ack_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            frame_q    <= frame_d;
            wreq_q     <= wreq_d;
            sample_q   <= sample_d;
            ack_q      <= ack_d;
            underrun_q <= underrun_d;
        end
    end

    assign grant        = grant_q;
    assign src_ack      = ack_q;
    assign audio_wreq   = wreq_q;
    assign audio_sample = sample_q;
    assign underrun     = underrun_q;

`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

    // Count is per ownership: any grant change, including to idle, restarts it.
    always_comb begin
        ucnt_d = ucnt_q;
        if (grant_d != grant_q) begin
            ucnt_d = '0;
        end else if (underrun_d && (ucnt_q != '1)) begin
            ucnt_d = ucnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_audio or posedge aclr) begin
        if (aclr) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_audio_stream_scheduler.sv
// Directed bench for audio_stream_scheduler: reset, grant, transfer, round-robin,
// underrun timing, deferred release and asynchronous abort.
module tb_audio_stream_scheduler;

    localparam int NS = 4;
    localparam int SW = 24;

    logic             clk_audio = 1'b0;
    logic             aclr;
    logic [NS-1:0]    src_req;
    logic [NS-1:0]    src_valid;
    logic [NS*SW-1:0] src_data;
    logic             audio_ready;
    wire  [NS-1:0]    src_ack;
    wire  [NS-1:0]    grant;
    wire              audio_wreq;
    wire  [SW-1:0]    audio_sample;
    wire              underrun;
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
    wire  [15:0]      underrun_count;
`endif

    int total = 0;
    int bad   = 0;

    audio_stream_scheduler dut (
        .clk_audio    (clk_audio),
        .aclr         (aclr),
        .src_req      (src_req),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ack      (src_ack),
        .grant        (grant),
        .audio_ready  (audio_ready),
        .audio_wreq   (audio_wreq),
        .audio_sample (audio_sample),
        .underrun     (underrun)
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk_audio = ~clk_audio;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_audio);
            #1;
        end
    endtask

    // Owner idx delivers one sample, returns to ARM, drops and re-raises its request.
    task automatic serve(input int idx, input logic [23:0] val, input logic [3:0] next_gnt);
        src_data[idx*SW +: SW] = val;
        src_valid[idx] = 1'b1;
        audio_ready    = 1'b1;
        step(1);
        chk("rr_wreq", 64'(audio_wreq), 64'd1);
        chk("rr_ack", 64'(src_ack), 64'(4'b0001 << idx));
        chk("rr_sample", 64'(audio_sample), 64'(val));
        src_valid[idx] = 1'b0;
        audio_ready    = 1'b0;
        step(2);
        src_req[idx] = 1'b0;
        step(1);
        chk("rr_release", 64'(grant), 64'd0);
        src_req[idx] = 1'b1;
        step(1);
        chk("rr_grant", 64'(grant), 64'(next_gnt));
    endtask

    int pulses;
    int first_at;

    initial begin
        aclr        = 1'b0;
        src_req     = '0;
        src_valid   = '0;
        src_data    = '0;
        audio_ready = 1'b0;
        #1 aclr = 1'b1;
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_ack", 64'(src_ack), 64'd0);
        chk("rst_wreq", 64'(audio_wreq), 64'd0);
        chk("rst_sample", 64'(audio_sample), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        step(2);
        aclr = 1'b0;
        step(1);
        chk("idle_grant", 64'(grant), 64'd0);

        // Request -> grant one cycle later.
        src_req = 4'b0001;
        step(1);
        chk("grant_first", 64'(grant), 64'h1);

        // Single transfer, then ready stays high: no second write.
        src_data[23:0] = 24'hABC123;
        src_valid      = 4'b0001;
        audio_ready    = 1'b1;
        step(1);
        chk("xfer_wreq", 64'(audio_wreq), 64'd1);
        chk("xfer_sample", 64'(audio_sample), 64'hABC123);
        chk("xfer_ack", 64'(src_ack), 64'h1);
        src_valid = 4'b0000;
        step(1);
        chk("xfer_wreq_drop", 64'(audio_wreq), 64'd0);
        chk("xfer_ack_drop", 64'(src_ack), 64'd0);
        chk("xfer_sample_hold", 64'(audio_sample), 64'hABC123);
        step(1);
        chk("drain_no_wreq1", 64'(audio_wreq), 64'd0);
        step(1);
        chk("drain_no_wreq2", 64'(audio_wreq), 64'd0);
        audio_ready = 1'b0;
        step(1);

        // Round-robin over all four producers.
        src_req = 4'b1111;
        serve(0, 24'h111111, 4'b0010);
        serve(1, 24'h222222, 4'b0100);
        serve(2, 24'h333333, 4'b1000);
        serve(3, 24'h444444, 4'b0001);

        // Underrun: owner 0 holds with no sample for two frames.
        src_req     = 4'b0001;
        src_valid   = 4'b0000;
        audio_ready = 1'b1;
        pulses      = 0;
        first_at    = 0;
        for (int i = 1; i <= 8192; i++) begin
            step(1);
            if (underrun === 1'b1) begin
                pulses++;
                if (first_at == 0) first_at = i;
            end
        end
        chk("ur_first_at", 64'(first_at), 64'd4096);
        chk("ur_pulses", 64'(pulses), 64'd2);
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
        chk("ur_count", 64'(underrun_count), 64'd2);
`endif
        audio_ready = 1'b0;
        step(1);
        chk("ur_quiet", 64'(underrun), 64'd0);

        // Release during the write is deferred until back in ARM.
        src_data[23:0] = 24'h5A5A5A;
        src_valid      = 4'b0001;
        audio_ready    = 1'b1;
        step(1);
        chk("defer_wreq", 64'(audio_wreq), 64'd1);
        chk("defer_ack", 64'(src_ack), 64'h1);
        src_req     = 4'b0000;
        src_valid   = 4'b0000;
        audio_ready = 1'b0;
        step(1);
        chk("defer_wreq_drop", 64'(audio_wreq), 64'd0);
        chk("defer_grant_write", 64'(grant), 64'h1);
        step(1);
        chk("defer_grant_arm", 64'(grant), 64'h1);
        step(1);
        chk("defer_grant_clear", 64'(grant), 64'd0);

        // Reset during WRITE aborts immediately; source 0 wins afterwards.
        src_req = 4'b0100;
        step(1);
        chk("abort_grant", 64'(grant), 64'h4);
        src_data[2*SW +: SW] = 24'h123456;
        src_valid   = 4'b0100;
        audio_ready = 1'b1;
        step(1);
        chk("abort_wreq", 64'(audio_wreq), 64'd1);
        chk("abort_ack", 64'(src_ack), 64'h4);
        #2 aclr = 1'b1;
        #1;
        chk("abort_wreq_clr", 64'(audio_wreq), 64'd0);
        chk("abort_ack_clr", 64'(src_ack), 64'd0);
        chk("abort_grant_clr", 64'(grant), 64'd0);
        chk("abort_sample_clr", 64'(audio_sample), 64'd0);
        @(posedge clk_audio);
        #3 aclr = 1'b0;
        src_req     = 4'b1111;
        src_valid   = 4'b0000;
        audio_ready = 1'b0;
        step(1);
        chk("post_rst_grant", 64'(grant), 64'h1);
        chk("post_rst_ack", 64'(src_ack), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
